// File: rtl/lcd_responder_pkg.sv
// Shared types and helpers for the HD44780-style LCD bus responder:
// bus modes, command classes, address-counter wrap points and buffer mapping.
package lcd_responder_pkg;

  typedef enum logic [1:0] {
    MODE_INIT8,
    MODE_HI,
    MODE_LO
  } mode_t;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISPLAY,
    CMD_SET_ADDR
  } cmd_t;

  localparam logic [3:0] NIB_FUNC_8BIT = 4'h3;
  localparam logic [3:0] NIB_FUNC_4BIT = 4'h2;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  localparam logic [6:0] AC_LINE1_FIRST = 7'h00;
  localparam logic [6:0] AC_LINE1_LAST  = 7'h27;
  localparam logic [6:0] AC_LINE2_FIRST = 7'h40;
  localparam logic [6:0] AC_LINE2_LAST  = 7'h67;

  localparam logic [4:0] LAST_ENTRY       = 5'd31;
  localparam int         MIN_CLEAR_CYCLES = 32;

  // Commands are classified by their highest set bit; shift, function set
  // and CGRAM addressing all collapse into CMD_NOP.
  function automatic cmd_t cmd_class(input logic [7:0] b);
    cmd_t c;
    if (b[7])             c = CMD_SET_ADDR;
    else if (b[6:4] != 0) c = CMD_NOP;
    else if (b[3])        c = CMD_DISPLAY;
    else if (b[2])        c = CMD_ENTRY;
    else if (b[1])        c = CMD_HOME;
    else if (b[0])        c = CMD_CLEAR;
    else                  c = CMD_NOP;
    return c;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (ac > AC_LINE2_LAST) begin
      nxt = AC_LINE1_FIRST;
    end else if (ac > AC_LINE1_LAST && ac < AC_LINE2_FIRST) begin
      nxt = AC_LINE2_FIRST;
    end else if (inc) begin
      if (ac == AC_LINE1_LAST)      nxt = AC_LINE2_FIRST;
      else if (ac == AC_LINE2_LAST) nxt = AC_LINE1_FIRST;
      else                          nxt = ac + 7'd1;
    end else begin
      if (ac == AC_LINE1_FIRST)      nxt = AC_LINE2_LAST;
      else if (ac == AC_LINE2_FIRST) nxt = AC_LINE1_LAST;
      else                           nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  // {visible, index}: only the first 16 columns of each line are mirrored.
  function automatic logic [5:0] ac_slot(input logic [6:0] ac);
    logic vis;
    vis = (ac[5:4] == 2'b00);
    return {vis, ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_responder_ddram.sv
// 32x8 character buffer: one synchronous write port, one registered read port.
// Contents are deliberately left untouched by reset.
module lcd_responder_ddram (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [0:31];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lcd_responder.sv
// Responder end of a 4-bit HD44780-style LCD bus: reassembles nibbles,
// decodes commands and data writes, and mirrors a 16x2 character buffer.
module lcd_responder
  import lcd_responder_pkg::*;
#(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_dat,
  output logic [3:0] lcd_dat_o,
  output logic       lcd_dat_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_rs,
  output logic       busy,
  output logic       disp_on,
  output logic       err
);

  localparam int CLEAR_EFF = (CLEAR_CYCLES > MIN_CLEAR_CYCLES) ? CLEAR_CYCLES : MIN_CLEAR_CYCLES;
  localparam int LONGEST   = (CLEAR_EFF > BUSY_CYCLES) ? CLEAR_EFF : BUSY_CYCLES;
  localparam int CNT_W     = $clog2(LONGEST + 1);

  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_EFF - 1);

  logic             e_q;
  logic             strobe;
  mode_t            mode;
  logic [3:0]       hi_nib;
  logic [6:0]       ac;
  logic             inc;
  logic             rd_phase;
  logic [CNT_W-1:0] busy_cnt;
  logic             fill_active;
  logic [4:0]       fill_idx;
  logic [7:0]       byte_now;
  cmd_t             cmd;
  logic [5:0]       slot;
  logic             char_we;
  logic             ram_we;
  logic [4:0]       ram_waddr;
  logic [7:0]       ram_wdata;

  assign strobe   = e_q & ~lcd_e;
  assign byte_now = {hi_nib, lcd_dat};
  assign cmd      = cmd_class(byte_now);
  assign slot     = ac_slot(ac);
  assign char_we  = strobe & ~lcd_rw & lcd_rs & (mode == MODE_LO) & ~busy & slot[5];

  // Fill wins the single write port; gating with rst makes reset abort it at once.
  always_comb begin
    ram_we    = rst & (fill_active | char_we);
    ram_waddr = slot[4:0];
    ram_wdata = byte_now;
    if (fill_active) begin
      ram_waddr = fill_idx;
      ram_wdata = SPACE_CHAR;
    end
  end

  lcd_responder_ddram u_ddram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      e_q         <= 1'b0;
      mode        <= MODE_INIT8;
      hi_nib      <= 4'h0;
      ac          <= AC_LINE1_FIRST;
      inc         <= 1'b1;
      rd_phase    <= 1'b0;
      busy        <= 1'b0;
      busy_cnt    <= '0;
      fill_active <= 1'b0;
      fill_idx    <= 5'd0;
      byte_valid  <= 1'b0;
      byte_out    <= 8'h00;
      byte_rs     <= 1'b0;
      disp_on     <= 1'b0;
      err         <= 1'b0;
      lcd_dat_o   <= 4'h0;
      lcd_dat_oe  <= 1'b0;
    end else begin
      e_q        <= lcd_e;
      byte_valid <= 1'b0;
      lcd_dat_oe <= lcd_e & lcd_rw;
      if (lcd_e && lcd_rw) begin
        lcd_dat_o <= rd_phase ? ac[3:0] : {busy, ac[6:4]};
      end else begin
        lcd_dat_o <= 4'h0;
      end

      if (busy) begin
        if (busy_cnt == '0) busy <= 1'b0;
        else                busy_cnt <= busy_cnt - CNT_W'(1);
      end

      if (fill_active) begin
        fill_idx <= fill_idx + 5'd1;
        if (fill_idx == LAST_ENTRY) fill_active <= 1'b0;
      end

      // Reads toggle their own phase and never disturb write nibble pairing.
      if (strobe && lcd_rw) begin
        rd_phase <= ~rd_phase;
      end else if (strobe) begin
        case (mode)
          MODE_INIT8: begin
            if (busy || lcd_rs ||
                (lcd_dat != NIB_FUNC_8BIT && lcd_dat != NIB_FUNC_4BIT)) begin
              err <= 1'b1;
            end else if (lcd_dat == NIB_FUNC_8BIT) begin
              busy     <= 1'b1;
              busy_cnt <= BUSY_LOAD;
            end else begin
              mode <= MODE_HI;
            end
          end
          MODE_HI: begin
            hi_nib <= lcd_dat;
            mode   <= MODE_LO;
          end
          MODE_LO: begin
            mode <= MODE_HI;
            if (busy) begin
              err <= 1'b1;
            end else begin
              byte_valid <= 1'b1;
              byte_out   <= byte_now;
              byte_rs    <= lcd_rs;
              busy       <= 1'b1;
              busy_cnt   <= BUSY_LOAD;
              if (lcd_rs) begin
                ac <= ac_step(ac, inc);
              end else begin
                case (cmd)
                  CMD_CLEAR: begin
                    fill_active <= 1'b1;
                    fill_idx    <= 5'd0;
                    ac          <= AC_LINE1_FIRST;
                    inc         <= 1'b1;
                    busy_cnt    <= CLEAR_LOAD;
                  end
                  CMD_HOME: begin
                    ac       <= AC_LINE1_FIRST;
                    busy_cnt <= CLEAR_LOAD;
                  end
                  CMD_ENTRY:    inc     <= byte_now[1];
                  CMD_DISPLAY:  disp_on <= byte_now[2];
                  CMD_SET_ADDR: ac      <= byte_now[6:0];
                  default: begin
                  end
                endcase
              end
            end
          end
          default: mode <= MODE_INIT8;
        endcase
      end
    end
  end

endmodule

// File: doc/lcd_responder.md
Name: lcd_responder

Overview:
- Responder end of the 4-bit HD44780-style LCD bus that the display block drives (lcd_e/lcd_rs/lcd_rw/lcd_dat).
- Reassembles nibbles into bytes and decodes commands and data writes into a 16x2 character buffer.
- Exposes the buffer on a debug read port and reports busy/error status.
- Used as a synthesizable bench responder, and on-chip as a display-mirror for debug readback.

Parameters:
BUSY_CYCLES, 2000, clk cycles busy after any completed byte except clear/home (40 us @ 50 MHz)
CLEAR_CYCLES, 82000, clk cycles busy after clear/home; effective value max(CLEAR_CYCLES, 32)

Ports:
clk  in  1  system clock; lcd_* inputs synchronous to it
rst  in  1  synchronous reset, active-low
lcd_e  in  1  enable strobe; bus sampled on falling edge
lcd_rs  in  1  0=command, 1=data
lcd_rw  in  1  0=write, 1=read
lcd_dat  in  4  nibble, high nibble first
lcd_dat_o  out  4  read-back nibble
lcd_dat_oe  out  1  read-back drive enable
rd_addr  in  5  buffer index: 0-15 line 1, 16-31 line 2
rd_data  out  8  buffer byte, 1-cycle latency
byte_valid  out  1  1-cycle pulse on each completed write byte
byte_out  out  8  last completed byte
byte_rs  out  1  rs of last completed byte
busy  out  1  busy flag
disp_on  out  1  display-on bit from display-control command
err  out  1  sticky: write strobe while busy

Behaviour:
- Reset (rst=0 at a clk edge):
  - Outputs: all 0, except rd_data, which reads the buffer.
  - Mode INIT8, address counter AC=0x00, increment=1.
  - Buffer is not cleared by reset.
  - Reset mid-operation aborts any clear fill or busy count immediately.
- Strobe detection:
  - e_q registers lcd_e; a strobe is e_q=1 && lcd_e=0.
  - rs/rw/dat are captured in that same cycle.
- INIT8 mode:
  - Each write strobe is one 8-bit command with upper nibble = dat.
  - dat=0x3: starts BUSY_CYCLES.
  - dat=0x2: switches to 4-bit mode (state HI); no busy.
  - Any other dat, or rs=1: sets err and is otherwise ignored.
- 4-bit mode, states HI and LO:
  - HI stores the high nibble, then goes to LO.
  - LO completes the byte, then returns to HI.
  - The completed byte pulses byte_valid the cycle after the LO strobe.
  - rw=1 strobes do not advance HI/LO.
  - Nibble pairing is never reset except by rst.
- Read strobes (rw=1, any mode):
  - While lcd_e=1, lcd_dat_oe=1.
  - Phase HI: lcd_dat_o = {busy, AC[6:4]}.
  - Phase LO: lcd_dat_o = AC[3:0].
  - Phase toggles on each read falling edge.
- Write while busy (byte completion or INIT8 strobe with busy=1): err<=1, strobe ignored.
- Command decode (rs=0), by highest set bit:
  - 0x01 clear: fill all 32 entries with 0x20, one entry per cycle; AC=0; increment=1; busy=CLEAR.
  - 0x02/03 home: AC=0; busy=CLEAR.
  - 0x04-07 entry mode: increment=bit1.
  - 0x08-0F: disp_on=bit2.
  - 0x10-3F (shift, function set) and 0x40-7F (CGRAM): no state change, busy=BUSY.
  - 0x80+: AC=byte[6:0], busy=BUSY.
- Data write (rs=1), busy=BUSY:
  - AC 0x00-0x0F writes entry AC; AC 0x40-0x4F writes entry 16+AC[3:0].
  - Other AC values: not stored.
  - Then AC steps per increment.
- AC wrap:
  - Increment: 0x27->0x40, 0x67->0x00.
  - Decrement: 0x00->0x67, 0x40->0x27.
  - Set-address values outside 0x00-27/0x40-67 are stored as given; the next step from such an AC maps into range by the same rules (>0x67 ->0x00; 0x28-0x3F ->0x40).
- Busy counter:
  - Loaded at byte completion; busy=1 from the next cycle for exactly N cycles.
  - Clear fill runs inside the busy window.
- Simultaneous read-port access during fill: rd_data returns the pre- or post-fill value; the fill itself has priority.

Decomposition:
- lcd_def.vh holds command codes, AC wrap constants, state encodings (INIT8/HI/LO) and the space character.
- Sub-module lcd_ddram: 32x8 RAM with one synchronous write port (char write or fill) and one registered read port.

Test Plan (BUSY_CYCLES=4, CLEAR_CYCLES=40):
- Init: nibbles 3,3,3,2 spaced >4 clk, then bytes 0x28, 0x0C -> no err; disp_on=1; busy high 4 cycles after each byte.
- Write "HI" (0x48, 0x49) after 0x01 -> rd_data[0]=0x48, rd_data[1]=0x49, rd_data[2..31]=0x20; busy exactly 40 cycles after clear.
- Set address 0xC0 (0x40), write 0x41 -> entry 16=0x41; busy-flag read returns lcd_dat_o=0x4 then 0x1.
- Entry mode 0x04, set address 0x80, write 0x5A -> entry 0 written, AC=0x67; next write stores nothing; AC=0x66.
- Second byte sent 1 cycle after previous completion -> err=1, entry unchanged; err held until rst=0.
- rst=0 during clear fill at cycle 10 -> busy=0, mode INIT8; byte 0x01 in INIT8 mode -> err (nibble 0x0).
